// File: rtl/benchmark_result_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : benchmark_defs (package)
// Description : Shared frame layout, state encodings and result-set type for
//               the benchmark result streamer.
// Revision    : 1.0 - initial release
// ============================================================================
package benchmark_defs;

    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

    localparam int FRAME_LEN_CHK   = 20;
    localparam int FRAME_LEN_NOCHK = 19;

    localparam logic [4:0] IDX_HDR = 5'd0;
    localparam logic [4:0] IDX_SEQ = 5'd1;
    localparam logic [4:0] IDX_WIN = 5'd2;
    localparam logic [4:0] IDX_C1  = 5'd3;
    localparam logic [4:0] IDX_C4  = 5'd15;
    localparam logic [4:0] IDX_CHK = 5'd19;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    typedef struct packed {
        logic [1:0]  winner;
        logic [31:0] cond1;
        logic [31:0] cond2;
        logic [31:0] cond3;
        logic [31:0] cond4;
    } result_set_t;

    // Counts are sent MS byte first, so position 0 is bits [31:24].
    function automatic logic [7:0] count_byte(input logic [31:0] count, input logic [1:0] pos);
        logic [7:0] b;
        case (pos)
            2'd0:    b = count[31:24];
            2'd1:    b = count[23:16];
            2'd2:    b = count[15:8];
            default: b = count[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/benchmark_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module      : benchmark_result_streamer_if
// Description : Valid/ready byte stream between the streamer and its sink.
// Revision    : 1.0 - initial release
// ============================================================================
interface benchmark_result_streamer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface
`default_nettype wire

// File: rtl/benchmark_result_streamer_frame_mux.sv
`default_nettype none
// ============================================================================
// Module      : result_frame_mux
// Description : Combinational selection of frame byte[i_idx] from the active
//               result set, sequence number and running checksum.
// Revision    : 1.0 - initial release
// ============================================================================
module result_frame_mux
    import benchmark_defs::*;
#(
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF
) (
    input  result_set_t i_set,
    input  logic [7:0]  i_seq,
    input  logic [7:0]  i_chk,
    input  logic [4:0]  i_idx,
    output logic [7:0]  o_byte
);

    logic [4:0]  w_off;
    logic [31:0] w_count;

    // Count bytes occupy 3..18: offset[3:2] picks the condition, offset[1:0] the byte.
    assign w_off = i_idx - IDX_C1;

    always_comb begin
        w_count = 32'h0;
        case (w_off[3:2])
            2'd0:    w_count = i_set.cond1;
            2'd1:    w_count = i_set.cond2;
            2'd2:    w_count = i_set.cond3;
            default: w_count = i_set.cond4;
        endcase
    end

    always_comb begin
        o_byte = 8'h00;
        if (i_idx == IDX_HDR) begin
            o_byte = HEADER_BYTE;
        end else if (i_idx == IDX_SEQ) begin
            o_byte = i_seq;
        end else if (i_idx == IDX_WIN) begin
            o_byte = {6'b0, i_set.winner};
        end else if (i_idx >= IDX_C1 && i_idx <= IDX_C4 + 5'd3) begin
            o_byte = count_byte(w_count, w_off[1:0]);
        end else if (i_idx == IDX_CHK) begin
            o_byte = i_chk;
        end
    end

endmodule
`default_nettype wire

// File: rtl/benchmark_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : benchmark_result_streamer
// Description : Captures benchmark results on done rising and streams them as
//               a fixed byte frame, holding one pending set and counting drops.
// Revision    : 1.0 - initial release
// ============================================================================
module benchmark_result_streamer
    import benchmark_defs::*;
#(
    parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEF,
    parameter bit         CHK_EN      = 1'b1,
    parameter int         DROP_W      = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      done,
    input  logic [1:0]                winner,
    input  logic [31:0]               cycle_count_cond1,
    input  logic [31:0]               cycle_count_cond2,
    input  logic [31:0]               cycle_count_cond3,
    input  logic [31:0]               cycle_count_cond4,
    benchmark_result_streamer_if.master tx,
    output logic                      busy,
    output logic [DROP_W-1:0]         drop_count
);

    localparam logic [4:0] c_last_idx = CHK_EN ? 5'(FRAME_LEN_CHK - 1) : 5'(FRAME_LEN_NOCHK - 1);

    logic [0:0]        r_state;
    logic              r_done_q;
    logic              r_pend_valid;
    result_set_t       r_active;
    result_set_t       r_pend;
    logic [7:0]        r_seq;
    logic [4:0]        r_idx;
    logic [7:0]        r_chk;
    logic [DROP_W-1:0] r_drop;

    result_set_t w_inputs;
    logic [7:0]  w_mux_byte;
    logic [7:0]  w_tx_data;
    logic        w_tx_valid;
    logic        w_rise;
    logic        w_accept;
    logic        w_last;

    assign w_inputs = '{winner: winner, cond1: cycle_count_cond1, cond2: cycle_count_cond2,
                        cond3: cycle_count_cond3, cond4: cycle_count_cond4};

    result_frame_mux #(
        .HEADER_BYTE (HEADER_BYTE)
    ) u_frame_mux (
        .i_set  (r_active),
        .i_seq  (r_seq),
        .i_chk  (r_chk),
        .i_idx  (r_idx),
        .o_byte (w_mux_byte)
    );

    // Output is forced to zero outside a frame so the bus idles quietly.
    assign w_tx_valid  = (r_state == ST_SEND);
    assign w_tx_data   = w_tx_valid ? w_mux_byte : 8'h00;
    assign tx.tx_valid = w_tx_valid;
    assign tx.tx_data  = w_tx_data;

    assign w_rise   = done & ~r_done_q;
    assign w_accept = w_tx_valid & tx.tx_ready;
    assign w_last   = w_accept && (r_idx == c_last_idx);

    assign busy       = (r_state != ST_IDLE) | r_pend_valid;
    assign drop_count = r_drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_done_q     <= 1'b0;
            r_pend_valid <= 1'b0;
            r_active     <= '0;
            r_pend       <= '0;
            r_seq        <= 8'h00;
            r_idx        <= 5'd0;
            r_chk        <= 8'h00;
            r_drop       <= '0;
        end else begin
            r_done_q <= done;
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        r_active <= w_inputs;
                        r_idx    <= 5'd0;
                        r_chk    <= 8'h00;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_last) begin
                        r_seq <= r_seq + 8'd1;
                        r_idx <= 5'd0;
                        r_chk <= 8'h00;
                        // Pending set goes out first; a coincident rise refills the slot.
                        if (r_pend_valid) begin
                            r_active <= r_pend;
                            if (w_rise) begin
                                r_pend <= w_inputs;
                            end else begin
                                r_pend_valid <= 1'b0;
                            end
                        end else if (w_rise) begin
                            r_active <= w_inputs;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        if (w_accept) begin
                            r_idx <= r_idx + 5'd1;
                            r_chk <= r_chk ^ w_tx_data;
                        end
                        if (w_rise) begin
                            if (!r_pend_valid) begin
                                r_pend       <= w_inputs;
                                r_pend_valid <= 1'b1;
                            end else if (r_drop != {DROP_W{1'b1}}) begin
                                r_drop <= r_drop + DROP_W'(1);
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_benchmark_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_benchmark_result_streamer
// Description : Randomised self-checking bench; two streamers (with and without
//               checksum) run against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_benchmark_result_streamer;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        done     = 1'b0;
    logic        tx_ready = 1'b0;
    logic [1:0]  winner   = 2'd0;
    logic [31:0] c1 = 32'd0, c2 = 32'd0, c3 = 32'd0, c4 = 32'd0;
    int          ready_pct = 100;

    logic       busy_chk, busy_nochk;
    logic [7:0] drop_chk, drop_nochk;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    benchmark_result_streamer_if if_chk ();
    benchmark_result_streamer_if if_nochk ();
    assign if_chk.tx_ready   = tx_ready;
    assign if_nochk.tx_ready = tx_ready;

    benchmark_result_streamer #(.CHK_EN(1'b1)) u_dut_chk (
        .clk (clk), .reset_n (reset_n), .done (done), .winner (winner),
        .cycle_count_cond1 (c1), .cycle_count_cond2 (c2),
        .cycle_count_cond3 (c3), .cycle_count_cond4 (c4),
        .tx (if_chk), .busy (busy_chk), .drop_count (drop_chk)
    );

    benchmark_result_streamer #(.CHK_EN(1'b0)) u_dut_nochk (
        .clk (clk), .reset_n (reset_n), .done (done), .winner (winner),
        .cycle_count_cond1 (c1), .cycle_count_cond2 (c2),
        .cycle_count_cond3 (c3), .cycle_count_cond4 (c4),
        .tx (if_nochk), .busy (busy_nochk), .drop_count (drop_nochk)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model: up to two held sets per streamer ----------------
    logic [129:0] m_slot [2][2];
    int           m_cnt  [2];
    int           m_bidx [2];
    int           m_obs_bytes [2];
    logic [7:0]   m_seq  [2];
    logic [7:0]   m_drop [2];
    logic [7:0]   m_prev_data [2];
    logic         m_stall [2];
    logic         m_prev_done;

    function automatic logic [7:0] body_byte(input logic [129:0] s, input logic [7:0] sq, input int idx);
        logic [31:0] cnt;
        if (idx == 0) return 8'hA5;
        if (idx == 1) return sq;
        if (idx == 2) return {6'b0, s[129:128]};
        cnt = s[127 - 32 * ((idx - 3) / 4) -: 32];
        return cnt[31 - 8 * ((idx - 3) % 4) -: 8];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [129:0] s, input logic [7:0] sq, input int idx);
        logic [7:0] x;
        if (idx < 19) return body_byte(s, sq, idx);
        x = 8'h00;
        for (int i = 0; i < 19; i++) x = x ^ body_byte(s, sq, i);
        return x;
    endfunction

    task automatic monitor_step();
        logic       rise;
        logic       v, b;
        logic [7:0] d, dc;
        int         len;
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k] = 0; m_bidx[k] = 0; m_seq[k] = 8'h00; m_drop[k] = 8'h00; m_stall[k] = 1'b0;
            end
            m_prev_done = 1'b0;
            return;
        end
        rise = done && !m_prev_done;
        for (int k = 0; k < 2; k++) begin
            len = (k == 0) ? 20 : 19;
            v  = (k == 0) ? if_chk.tx_valid : if_nochk.tx_valid;
            d  = (k == 0) ? if_chk.tx_data  : if_nochk.tx_data;
            b  = (k == 0) ? busy_chk        : busy_nochk;
            dc = (k == 0) ? drop_chk        : drop_nochk;
            check_val($sformatf("tx_valid[%0d]", k), 32'(v), 32'(m_cnt[k] != 0));
            check_val($sformatf("busy[%0d]", k), 32'(b), 32'(m_cnt[k] != 0));
            check_val($sformatf("drop_count[%0d]", k), 32'(dc), 32'(m_drop[k]));
            if (v && m_cnt[k] != 0) begin
                check_val($sformatf("tx_data[%0d] idx%0d", k, m_bidx[k]), 32'(d),
                          32'(frame_byte(m_slot[k][0], m_seq[k], m_bidx[k])));
                if (m_stall[k]) check_val($sformatf("hold_data[%0d]", k), 32'(d), 32'(m_prev_data[k]));
            end
            m_stall[k]     = v && !tx_ready;
            m_prev_data[k] = d;
            if (v && tx_ready) m_obs_bytes[k]++;
            if (v && tx_ready && m_cnt[k] != 0) begin
                if (m_bidx[k] == len - 1) begin
                    m_bidx[k] = 0;
                    m_seq[k]  = m_seq[k] + 8'd1;
                    m_slot[k][0] = m_slot[k][1];
                    m_cnt[k]--;
                end else begin
                    m_bidx[k]++;
                end
            end
            if (rise) begin
                if (m_cnt[k] < 2) begin
                    m_slot[k][m_cnt[k]] = {winner, c1, c2, c3, c4};
                    m_cnt[k]++;
                end else if (m_drop[k] != 8'hFF) begin
                    m_drop[k] = m_drop[k] + 8'd1;
                end
            end
        end
        m_prev_done = done;
    endtask

    always @(negedge clk) monitor_step();

    initial begin
        m_obs_bytes[0] = 0;
        m_obs_bytes[1] = 0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input logic [1:0] w, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] e, input int hold);
        @(posedge clk);
        #1;
        winner = w; c1 = a; c2 = b; c3 = c; c4 = e;
        done = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_cnt[0] != 0 || m_cnt[1] != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check_val("idle_timeout", 32'(n < 3000), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    int b0, b1;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("reset_tx_valid", 32'(if_chk.tx_valid), 32'd0);
        check_val("reset_tx_data", 32'(if_chk.tx_data), 32'd0);
        check_val("reset_busy", 32'(busy_chk), 32'd0);

        // Basic frame with an always-ready sink
        ready_pct = 100;
        b0 = m_obs_bytes[0]; b1 = m_obs_bytes[1];
        pulse(2'd3, 32'd100, 32'd200, 32'd300, 32'd50, 1);
        wait_idle();
        check_val("basic_len_chk", 32'(m_obs_bytes[0] - b0), 32'd20);
        check_val("basic_len_nochk", 32'(m_obs_bytes[1] - b1), 32'd19);

        // Backpressure
        ready_pct = 30;
        pulse(2'd3, 32'd100, 32'd200, 32'd300, 32'd50, 1);
        wait_idle();

        // Back-to-back: second set arrives mid-frame
        ready_pct = 100;
        pulse(2'd1, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 1);
        repeat (4) @(posedge clk);
        pulse(2'd2, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'h12345678, 1);
        wait_idle();
        check_val("b2b_drop", 32'(drop_chk), 32'd0);

        // Overflow: third set during one frame is lost
        pulse(2'd0, 32'd1, 32'd2, 32'd3, 32'd4, 1);
        pulse(2'd1, 32'd5, 32'd6, 32'd7, 32'd8, 1);
        pulse(2'd2, 32'd9, 32'd10, 32'd11, 32'd12, 1);
        wait_idle();
        check_val("ovf_drop_chk", 32'(drop_chk), 32'd1);
        check_val("ovf_drop_nochk", 32'(drop_nochk), 32'd1);

        // Reset mid-frame
        pulse(2'd3, 32'hAAAA5555, 32'd7, 32'd8, 32'd9, 1);
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("rst_mid_valid", 32'(if_chk.tx_valid), 32'd0);
        check_val("rst_mid_busy", 32'(busy_chk), 32'd0);
        check_val("rst_mid_drop", 32'(drop_chk), 32'd0);
        check_val("rst_mid_data", 32'(if_chk.tx_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        pulse(2'd2, 32'd11, 32'd22, 32'd33, 32'd44, 1);
        wait_idle();

        // Level done held 7 cycles yields one all-zero frame
        b0 = m_obs_bytes[0]; b1 = m_obs_bytes[1];
        pulse(2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 7);
        wait_idle();
        check_val("level_len_chk", 32'(m_obs_bytes[0] - b0), 32'd20);
        check_val("level_len_nochk", 32'(m_obs_bytes[1] - b1), 32'd19);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            ready_pct = $urandom_range(20, 100);
            pulse(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom,
                  $urandom_range(1, 3));
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        ready_pct = 100;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
